// File: rtl/rotfpga_scan_ctrl_if.sv
// Control/data bundle between the pin decode, the scan controller and the tile array.
interface rotfpga_scan_ctrl_if #(
  parameter int unsigned TILES         = 16,
  parameter int unsigned BITS_PER_TILE = 4
) ();
  localparam int unsigned N  = TILES * BITS_PER_TILE;
  localparam int unsigned CW = $clog2(N);

  logic          scan_en;
  logic          scan_in;
  logic          loop_en;
  logic          commit;
  logic          rot_start;
  logic [CW-1:0] rot_amt;
  logic          scan_out;
  logic [N-1:0]  cfg_out;
  logic [CW-1:0] shift_cnt;
  logic          frame_done;
  logic          busy;

  modport master (
    output scan_en, scan_in, loop_en, commit, rot_start, rot_amt,
    input  scan_out, cfg_out, shift_cnt, frame_done, busy
  );

  modport slave (
    input  scan_en, scan_in, loop_en, commit, rot_start, rot_amt,
    output scan_out, cfg_out, shift_cnt, frame_done, busy
  );
endinterface

// File: rtl/rotfpga_scan_ctrl.sv
// Configuration scan-chain controller: shadow chain with commit-based double
// buffering, autonomous loopback rotation engine and frame-wrap tracking.
module rotfpga_scan_ctrl #(
  parameter int unsigned TILES         = 16,
  parameter int unsigned BITS_PER_TILE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rotfpga_scan_ctrl_if.slave   bus
);
  localparam int unsigned N  = TILES * BITS_PER_TILE;
  localparam int unsigned CW = $clog2(N);

  typedef enum logic {IDLE = 1'b0, ROT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [N-1:0]  shadow_q, shadow_d;
  logic [N-1:0]  active_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          frame_done_q;
  logic          busy_q;
  logic          do_shift;
  logic          shift_bit;
  logic          wrap;

  // Next-state, shift source selection and counter wrap decode.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    do_shift  = 1'b0;
    shift_bit = bus.scan_in;
    unique case (state_q)
      IDLE: begin
        if (bus.rot_start && (bus.rot_amt != CW'(0))) begin
          state_d = ROT;
          rem_d   = bus.rot_amt;
        end else if (bus.scan_en) begin
          do_shift  = 1'b1;
          shift_bit = bus.loop_en ? shadow_q[N-1] : bus.scan_in;
        end
      end
      ROT: begin
        do_shift  = 1'b1;
        shift_bit = shadow_q[N-1];
        rem_d     = rem_q - CW'(1);
        if (rem_q == CW'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    shadow_d = do_shift ? {shadow_q[N-2:0], shift_bit} : shadow_q;
    wrap     = do_shift && (cnt_q == CW'(N - 1));
    if (!do_shift) begin
      cnt_d = cnt_q;
    end else if (wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State, chain, counter and flag registers; commit samples pre-edge shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      shadow_q     <= shadow_d;
      cnt_q        <= cnt_d;
      frame_done_q <= wrap;
      busy_q       <= (state_d == ROT);
      if (bus.commit) begin
        active_q <= shadow_q;
      end
    end
  end

  assign bus.scan_out   = shadow_q[N-1];
  assign bus.cfg_out    = active_q;
  assign bus.shift_cnt  = cnt_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_rotfpga_scan_ctrl.sv
// Directed self-checking bench for rotfpga_scan_ctrl (16 tiles x 4 bits).
module tb_rotfpga_scan_ctrl;
  localparam int unsigned TILES = 16;
  localparam int unsigned BPT   = 4;
  localparam int unsigned N     = TILES * BPT;
  localparam int unsigned CW    = $clog2(N);

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  rotfpga_scan_ctrl_if #(.TILES(TILES), .BITS_PER_TILE(BPT)) bus ();

  rotfpga_scan_ctrl #(.TILES(TILES), .BITS_PER_TILE(BPT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.scan_en   = 1'b0;
    bus.scan_in   = 1'b0;
    bus.loop_en   = 1'b0;
    bus.commit    = 1'b0;
    bus.rot_start = 1'b0;
    bus.rot_amt   = '0;
  endtask

  initial begin
    logic [63:0] pat;
    logic [63:0] exp_sh;
    logic [9:0]  extra;
    logic        d;

    vectors     = 0;
    miscompares = 0;
    pat         = 64'hA5A5_0F0F_1234_FEDC;
    extra       = 10'h2B5;

    // Reset with random inputs
    rst_n         = 1'b0;
    bus.scan_en   = 1'($urandom);
    bus.scan_in   = 1'($urandom);
    bus.loop_en   = 1'($urandom);
    bus.commit    = 1'($urandom);
    bus.rot_start = 1'($urandom);
    bus.rot_amt   = CW'($urandom);
    repeat (3) step();
    chk("rst_cfg", 64'(bus.cfg_out), 64'h0);
    chk("rst_scan_out", 64'(bus.scan_out), 64'h0);
    chk("rst_shift_cnt", 64'(bus.shift_cnt), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_frame_done", 64'(bus.frame_done), 64'h0);
    idle_inputs();
    rst_n = 1'b1;
    repeat (2) step();
    chk("post_rst_cfg", 64'(bus.cfg_out), 64'h0);
    chk("post_rst_cnt", 64'(bus.shift_cnt), 64'h0);
    chk("post_rst_busy", 64'(bus.busy), 64'h0);

    // Full frame load, MSB first
    for (int i = 63; i >= 0; i--) begin
      bus.scan_en = 1'b1;
      bus.scan_in = pat[i];
      step();
      chk($sformatf("load_frame_done_%0d", i), 64'(bus.frame_done), (i == 0) ? 64'h1 : 64'h0);
    end
    chk("load_cnt", 64'(bus.shift_cnt), 64'h0);
    chk("load_scan_out", 64'(bus.scan_out), 64'(pat[63]));
    bus.scan_en = 1'b0;
    bus.commit  = 1'b1;
    step();
    bus.commit = 1'b0;
    chk("load_cfg", 64'(bus.cfg_out), pat);
    chk("load_frame_done_drop", 64'(bus.frame_done), 64'h0);

    // Double buffer: shadow moves, active holds until commit
    exp_sh = pat;
    for (int j = 0; j < 10; j++) begin
      d           = extra[j];
      bus.scan_en = 1'b1;
      bus.scan_in = d;
      exp_sh      = {exp_sh[62:0], d};
      step();
    end
    chk("dbuf_cfg_hold", 64'(bus.cfg_out), pat);
    chk("dbuf_cnt", 64'(bus.shift_cnt), 64'd10);
    bus.scan_in = 1'b1;
    bus.commit  = 1'b1;
    step();
    bus.commit = 1'b0;
    chk("dbuf_commit_pre_edge", 64'(bus.cfg_out), exp_sh);
    chk("dbuf_cnt11", 64'(bus.shift_cnt), 64'd11);

    // Load shadow = 0x1 (63 zeros then a one)
    for (int j = 0; j < 64; j++) begin
      bus.scan_en = 1'b1;
      bus.scan_in = (j == 63);
      step();
    end
    bus.scan_en = 1'b0;
    chk("one_cnt", 64'(bus.shift_cnt), 64'd11);

    // Rotate by 5 while scan/rot_start activity must be ignored
    bus.rot_start = 1'b1;
    bus.rot_amt   = CW'(5);
    step();
    chk("rot5_busy_start", 64'(bus.busy), 64'h1);
    bus.rot_amt = CW'(3);
    for (int i = 1; i <= 5; i++) begin
      bus.scan_en = 1'b1;
      bus.scan_in = 1'(i);
      bus.loop_en = 1'b0;
      step();
      chk($sformatf("rot5_busy_%0d", i), 64'(bus.busy), (i < 5) ? 64'h1 : 64'h0);
    end
    idle_inputs();
    chk("rot5_cnt", 64'(bus.shift_cnt), 64'd16);
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    chk("rot5_shadow", 64'(bus.cfg_out), 64'h20);

    // Zero-length rotation is a no-op
    bus.rot_start = 1'b1;
    bus.rot_amt   = '0;
    step();
    chk("rot0_busy", 64'(bus.busy), 64'h0);
    bus.rot_start = 1'b0;
    step();
    chk("rot0_busy2", 64'(bus.busy), 64'h0);
    chk("rot0_cnt", 64'(bus.shift_cnt), 64'd16);

    // Rotate 58 steps: bit 5 -> bit 63, counter wraps mid-rotation
    bus.rot_start = 1'b1;
    bus.rot_amt   = CW'(58);
    step();
    bus.rot_start = 1'b0;
    for (int j = 1; j <= 58; j++) begin
      step();
      if (j == 48 || j == 49)
        chk($sformatf("rot58_frame_done_%0d", j), 64'(bus.frame_done), (j == 48) ? 64'h1 : 64'h0);
      if (j == 57 || j == 58)
        chk($sformatf("rot58_busy_%0d", j), 64'(bus.busy), (j < 58) ? 64'h1 : 64'h0);
    end
    chk("rot58_cnt", 64'(bus.shift_cnt), 64'd10);
    chk("rot58_scan_out", 64'(bus.scan_out), 64'h1);
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    chk("rot58_shadow", 64'(bus.cfg_out), 64'h8000_0000_0000_0000);

    // External loopback shift wraps MSB into bit 0
    bus.scan_en = 1'b1;
    bus.loop_en = 1'b1;
    bus.scan_in = 1'b0;
    step();
    idle_inputs();
    chk("loop_scan_out", 64'(bus.scan_out), 64'h0);
    chk("loop_cnt", 64'(bus.shift_cnt), 64'd11);
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    chk("loop_shadow", 64'(bus.cfg_out), 64'h1);

    // Reset during the third busy cycle of a 40-step rotation
    bus.rot_start = 1'b1;
    bus.rot_amt   = CW'(40);
    step();
    bus.rot_start = 1'b0;
    step();
    step();
    chk("mid_busy_before", 64'(bus.busy), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'h0);
    chk("mid_rst_cfg", 64'(bus.cfg_out), 64'h0);
    chk("mid_rst_cnt", 64'(bus.shift_cnt), 64'h0);
    chk("mid_rst_scan_out", 64'(bus.scan_out), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    chk("mid_post_busy", 64'(bus.busy), 64'h0);
    chk("mid_post_cnt", 64'(bus.shift_cnt), 64'h0);
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    chk("mid_post_shadow", 64'(bus.cfg_out), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rotfpga_scan_ctrl.md
# rotfpga_scan_ctrl

Parametrised configuration scan-chain controller for the rotatable-tile FPGA. It holds a shadow scan chain of TILES×BITS_PER_TILE configuration bits and a separate active copy that drives the tile array. It adds three things the single fixed chain does not have: commit-based double buffering, an autonomous N-step loopback rotation engine, and frame-wrap tracking. It sits between the top-level pin decode (scan enable / scan data / loopback pins) and the tile array configuration inputs.

## Interface
Parameters:
- TILES, 16, number of tiles in the chain
- BITS_PER_TILE, 4, configuration bits per tile
- Derived: N = TILES*BITS_PER_TILE (N ≥ 2); CW = $clog2(N)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- scan_en  in  1  shift shadow chain by one bit this cycle (IDLE only)
- scan_in  in  1  serial data into shadow bit 0
- loop_en  in  1  with scan_en: feed scan_out back instead of scan_in
- commit  in  1  copy shadow chain into active register
- rot_start  in  1  start autonomous rotation of rot_amt steps
- rot_amt  in  CW  rotation step count, 0..N-1; 0 means no-op
- scan_out  out  1  shadow[N-1]
- cfg_out  out  N  active configuration; tile t = cfg_out[t*BITS_PER_TILE +: BITS_PER_TILE]
- shift_cnt  out  CW  shifts performed modulo N
- frame_done  out  1  one-cycle pulse after shift_cnt wraps N-1→0
- busy  out  1  rotation engine active

## Operation
- Shift: shadow ← {shadow[N-2:0], d}. d = scan_out when loop_en, else scan_in. Each shift moves bit i to bit i+1, so a loopback shift is a rotate-left by one.
- Shifts come from two sources: external (scan_en in IDLE) or rotation (every ROT cycle, always loopback). Both advance shift_cnt.
- shift_cnt increments per shift and wraps explicitly from N-1 to 0; N need not be a power of two. On the wrapping edge, frame_done is registered high for exactly one cycle, and only if another wrap happens on the next edge does it stay high.
- Commit: active ← shadow as it was before the edge. This holds even if a shift happens on the same edge. Commit is honoured in both IDLE and ROT. cfg_out changes only on commit.
- FSM states:
  - IDLE: rot_start=1 with rot_amt≠0 moves to ROT with remaining=rot_amt. No shift happens on that edge, and scan_en is ignored that cycle. rot_start with rot_amt=0 is ignored, and scan_en acts normally.
  - ROT: each edge performs one loopback shift and decrements remaining. When the edge consumes remaining==1, the FSM returns to IDLE. scan_en, loop_en and rot_start are ignored in ROT.
- busy = (state==ROT).

## Timing
- Reset (async, immediate): shadow=0, active=0 (cfg_out=0), scan_out=0, shift_cnt=0, frame_done=0, busy=0, state=IDLE, remaining=0.
- Reset mid-rotation aborts the rotation with no partial commit. Operation resumes on the first edge after rst_n rises.
- External shift: scan_out and shift_cnt update on the same edge that samples scan_en.
- Rotation: rot_start sampled at edge k → busy=1 after k. Shifts occur at edges k+1..k+rot_amt. busy=0 after edge k+rot_amt, so busy stays high for exactly rot_amt cycles. A new rot_start is accepted at edge k+rot_amt+1 at the earliest.
- frame_done is high during the cycle following the wrapping edge.
- A full external frame takes N scan_en cycles; the first bit shifted in lands in shadow[N-1].

## Test plan
- Reset: drive inputs random, hold rst_n=0 → cfg_out=0, scan_out=0, shift_cnt=0, busy=0, frame_done=0. Then release rst_n and check values are stable with scan_en=0.
- Full load (N=64): shift 64 bits of 0xA5A5_0F0F_1234_FEDC, MSB first, then commit → cfg_out=0xA5A5_0F0F_1234_FEDC. frame_done pulses once, after the 64th edge, and shift_cnt=0.
- Double buffer: after the full load, shift 10 more bits without commit → cfg_out unchanged, shift_cnt=10. Pulse commit together with the 11th shift → cfg_out equals the shadow after 10 shifts.
- Rotation: shadow=0x1, rot_start with rot_amt=5 while toggling scan_en/scan_in → busy high for exactly 5 cycles, shadow=0x20, shift_cnt advances by 5. Then rot_amt=0 with rot_start → busy stays 0.
- Loopback external: shadow=0x8000_0000_0000_0000, scan_en=1, loop_en=1 for 1 cycle → shadow=0x1, scan_out=0.
- Reset mid-operation: rot_amt=40, assert rst_n=0 during the 3rd busy cycle → busy=0, shadow=0, cfg_out=0, shift_cnt=0 immediately, with no further shifts after release.
